// File: rtl/tinker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tinker_pkg
// Description : Shared constants and types for the Tinker register file
//               and its pending-write scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
package tinker_pkg;

    // Architectural register file geometry
    localparam int NUM_REGS = 32;
    localparam int REG_AW   = $clog2(NUM_REGS);

    // Stack pointer location and its power-on value
    localparam int          SP_IDX   = 31;
    localparam logic [63:0] SP_RESET = 64'd524288;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [63:0]       word_t;

endpackage : tinker_pkg
`default_nettype wire

// File: rtl/tinker_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tinker_scoreboard
// Description : Pending-write scoreboard. Tracks registers that have an
//               in-flight producer, arbitrates claim versus write-back on
//               the same register, reports population count and a sticky
//               error for write-backs to registers nobody claimed.
// Revision    : 1.0 - initial release
// ============================================================================
module tinker_scoreboard #(
    parameter int NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int NUM_WR   = 2,
    localparam int AW      = $clog2(NUM_REGS),
    localparam int CW      = AW + 1
) (
    input  logic                         clk,
    input  logic                         reset,        // synchronous, active-low
    input  logic                         i_iss_valid,
    input  logic [AW-1:0]                i_iss_dst,
    output logic                         o_iss_ready,
    input  logic [NUM_WR-1:0]            i_wb_valid,
    input  logic [NUM_WR-1:0][AW-1:0]    i_wb_addr,
    output logic [NUM_REGS-1:0]          o_pending,
    output logic [CW-1:0]                o_pend_cnt,
    output logic                         o_wb_err
);

    import tinker_pkg::*;

    logic [NUM_REGS-1:0] r_pending;
    logic                r_wb_err;

    logic [NUM_REGS-1:0] w_pending_nxt;
    logic                w_claim;
    logic                w_err_hit;
    logic [CW-1:0]       w_cnt;

    // Next pending vector: clears from write-backs first, then the claim,
    // so a new producer on the same register supersedes the retiring one.
    always_comb begin
        w_pending_nxt = r_pending;
        w_err_hit     = 1'b0;
        w_claim       = i_iss_valid && !r_pending[i_iss_dst] && (i_iss_dst != '0);
        for (int j = 0; j < NUM_WR; j++) begin
            if (i_wb_valid[j]) begin
                w_pending_nxt[i_wb_addr[j]] = 1'b0;
                // Error is judged against the state before this edge
                if ((i_wb_addr[j] != '0) && !r_pending[i_wb_addr[j]]) begin
                    w_err_hit = 1'b1;
                end
            end
        end
        if (w_claim) begin
            w_pending_nxt[i_iss_dst] = 1'b1;
        end
        // Register 0 is hardwired and can never have a producer
        w_pending_nxt[0] = 1'b0;
    end

    // Pending vector and sticky error register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pending <= '0;
            r_wb_err  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_wb_err  <= r_wb_err | w_err_hit;
        end
    end

    // Population count of the registered pending vector
    always_comb begin
        w_cnt = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            w_cnt = w_cnt + CW'(r_pending[k]);
        end
    end

    assign o_iss_ready = !r_pending[i_iss_dst];
    assign o_pending   = r_pending;
    assign o_pend_cnt  = w_cnt;
    assign o_wb_err    = r_wb_err;

endmodule : tinker_scoreboard
`default_nettype wire

// File: rtl/tinker_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tinker_regfile_sb
// Description : Multi-port architectural register file for the pipelined
//               Tinker core with an integrated pending-write scoreboard.
//               NUM_RD combinational read ports, NUM_WR write-back ports
//               (higher port index wins on address collision), register 0
//               hardwired to zero, stack pointer exported.
//               Optional feature macro: TINKER_RF_BYPASS_EN - forwards
//               same-cycle write-back data and readiness to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tinker_regfile_sb #(
    parameter int          DATA_W   = 64,
    parameter int          NUM_REGS = tinker_pkg::NUM_REGS,
    parameter int          NUM_RD   = 3,
    parameter int          NUM_WR   = 2,
    parameter int          SP_IDX   = tinker_pkg::SP_IDX,
    parameter logic [63:0] SP_RESET = tinker_pkg::SP_RESET,
    localparam int         AW       = $clog2(NUM_REGS)
) (
    input  logic                             clk,
    input  logic                             reset,      // synchronous, active-low
    input  logic [NUM_RD-1:0][AW-1:0]        rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]                rd_ready,
    input  logic                             iss_valid,
    input  logic [AW-1:0]                    iss_dst,
    output logic                             iss_ready,
    input  logic [NUM_WR-1:0]                wb_valid,
    input  logic [NUM_WR-1:0][AW-1:0]        wb_addr,
    input  logic [NUM_WR-1:0][DATA_W-1:0]    wb_data,
    output logic [DATA_W-1:0]                stack_ptr,
    output logic [AW:0]                      pend_cnt,
    output logic                             wb_err
);

    import tinker_pkg::*;

    localparam logic [DATA_W-1:0] c_sp_init = DATA_W'(SP_RESET);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [NUM_REGS-1:0] w_pending;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    tinker_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR)
    ) u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .i_iss_valid (iss_valid),
        .i_iss_dst   (iss_dst),
        .o_iss_ready (iss_ready),
        .i_wb_valid  (wb_valid),
        .i_wb_addr   (wb_addr),
        .o_pending   (w_pending),
        .o_pend_cnt  (pend_cnt),
        .o_wb_err    (wb_err)
    );

    // Register storage: later write ports overwrite earlier ones on the
    // same address because the last non-blocking assignment takes effect.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= (k == SP_IDX) ? c_sp_init : '0;
            end
        end else begin
            for (int j = 0; j < NUM_WR; j++) begin
                if (wb_valid[j] && (wb_addr[j] != '0)) begin
                    r_regs[wb_addr[j]] <= wb_data[j];
                end
            end
        end
    end

    // Read ports: stored state, optionally overridden by the winning
    // same-cycle write-back (scan in port order so the highest port wins).
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i]  = r_regs[rd_addr[i]];
            rd_ready[i] = !w_pending[rd_addr[i]];
`ifdef TINKER_RF_BYPASS_EN
            for (int j = 0; j < NUM_WR; j++) begin
                if (wb_valid[j] && (wb_addr[j] == rd_addr[i]) && (rd_addr[i] != '0)) begin
                    rd_data[i]  = wb_data[j];
                    rd_ready[i] = 1'b1;
                end
            end
`else
            // No forwarding: readers see only committed state
`endif
        end
    end

    // Stack pointer always reflects committed state, never the bypass
    assign stack_ptr = r_regs[SP_IDX];

endmodule : tinker_regfile_sb
`default_nettype wire

// File: tb/tb_tinker_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : tb_tinker_regfile_sb
// Description : Self-checking bench for tinker_regfile_sb. Directed
//               scenarios followed by randomized traffic, all compared
//               against an array-based reference model of the register
//               file and its scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tinker_regfile_sb;

    localparam int          DATA_W   = 64;
    localparam int          NUM_REGS = 32;
    localparam int          NUM_RD   = 3;
    localparam int          NUM_WR   = 2;
    localparam int          AW       = 5;
    localparam int          SP_IDX   = 31;
    localparam logic [63:0] SP_RESET = 64'd524288;
`ifdef TINKER_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                          clk = 1'b0;
    logic                          reset;
    logic [NUM_RD-1:0][AW-1:0]     rd_addr;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]             rd_ready;
    logic                          iss_valid;
    logic [AW-1:0]                 iss_dst;
    logic                          iss_ready;
    logic [NUM_WR-1:0]             wb_valid;
    logic [NUM_WR-1:0][AW-1:0]     wb_addr;
    logic [NUM_WR-1:0][DATA_W-1:0] wb_data;
    logic [DATA_W-1:0]             stack_ptr;
    logic [AW:0]                   pend_cnt;
    logic                          wb_err;

    tinker_regfile_sb dut (
        .clk       (clk),
        .reset     (reset),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ready  (rd_ready),
        .iss_valid (iss_valid),
        .iss_dst   (iss_dst),
        .iss_ready (iss_ready),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .stack_ptr (stack_ptr),
        .pend_cnt  (pend_cnt),
        .wb_err    (wb_err)
    );

    always #5 clk = ~clk;

    // Reference model
    logic [63:0] m_regs [NUM_REGS];
    bit          m_pend [NUM_REGS];
    bit          m_err;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    function automatic int pend_count();
        int c = 0;
        for (int r = 0; r < NUM_REGS; r++) c += int'(m_pend[r]);
        return c;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NUM_REGS; r++) begin
            m_regs[r] = (r == SP_IDX) ? SP_RESET : 64'd0;
            m_pend[r] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    // One clock edge worth of architectural behaviour
    task automatic model_update();
        bit old [NUM_REGS];
        old = m_pend;
        for (int j = 0; j < NUM_WR; j++) begin
            if (wb_valid[j] && wb_addr[j] != 0) begin
                if (!old[wb_addr[j]]) m_err = 1'b1;
                m_regs[wb_addr[j]] = wb_data[j];
            end
        end
        for (int j = 0; j < NUM_WR; j++)
            if (wb_valid[j]) m_pend[wb_addr[j]] = 1'b0;
        if (iss_valid && iss_dst != 0 && !old[iss_dst]) m_pend[iss_dst] = 1'b1;
    endtask

    task automatic check_model();
        for (int i = 0; i < NUM_RD; i++) begin
            logic [63:0] d;
            bit          r;
            int          a;
            a = int'(rd_addr[i]);
            d = m_regs[a];
            r = !m_pend[a];
            if (BYP) begin
                for (int j = 0; j < NUM_WR; j++)
                    if (wb_valid[j] && int'(wb_addr[j]) == a && a != 0) begin
                        d = wb_data[j];
                        r = 1'b1;
                    end
            end
            check($sformatf("rd_data[%0d] r%0d", i, a), rd_data[i], d);
            check($sformatf("rd_ready[%0d] r%0d", i, a), 64'(rd_ready[i]), 64'(r));
        end
        check("iss_ready", 64'(iss_ready), 64'(!m_pend[iss_dst]));
        check("pend_cnt", 64'(pend_cnt), 64'(pend_count()));
        check("stack_ptr", stack_ptr, m_regs[SP_IDX]);
        check("wb_err", 64'(wb_err), 64'(m_err));
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic advance();
        @(posedge clk);
        if (!reset) model_reset();
        else        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        advance();
    endtask

    task automatic idle();
        iss_valid = 1'b0;
        wb_valid  = '0;
    endtask

    task automatic wb(input int port, input int addr, input logic [63:0] data);
        wb_valid[port] = 1'b1;
        wb_addr[port]  = AW'(addr);
        wb_data[port]  = data;
    endtask

    task automatic claim(input int addr);
        iss_valid = 1'b1;
        iss_dst   = AW'(addr);
    endtask

    task automatic do_reset(input int cycles);
        idle();
        reset = 1'b0;
        repeat (cycles) advance();
        reset = 1'b1;
    endtask

    initial begin
        int plist[$];
        reset   = 1'b0;
        rd_addr = '0;
        iss_dst = '0;
        wb_addr = '0;
        wb_data = '0;
        idle();
        do_reset(2);

        // Reset state sweep over all registers
        for (int a = 0; a < NUM_REGS; a += NUM_RD) begin
            for (int i = 0; i < NUM_RD; i++) rd_addr[i] = AW'((a + i) % NUM_REGS);
            sample();
            for (int i = 0; i < NUM_RD; i++)
                if (((a + i) % NUM_REGS) != SP_IDX) check("reset_rd_zero", rd_data[i], 64'd0);
            if (a == 0) begin
                check("reset_sp", stack_ptr, 64'd524288);
                check("reset_pend_cnt", 64'(pend_cnt), 64'd0);
                check("reset_wb_err", 64'(wb_err), 64'd0);
            end
            advance();
        end

        // Claim r5, write it back two cycles later
        rd_addr = '0;
        rd_addr[0] = AW'(5);
        claim(5);
        sample(); check("claim_r5_accept", 64'(iss_ready), 64'd1); advance();
        idle();
        sample(); check("r5_pending_c1", 64'(rd_ready[0]), 64'd0);
        check("pend_cnt_one", 64'(pend_cnt), 64'd1); advance();
        wb(0, 5, 64'hDEAD);
        sample(); check("r5_pending_c2", 64'(rd_ready[0]), 64'(BYP)); advance();
        idle();
        sample(); check("r5_data", rd_data[0], 64'hDEAD);
        check("r5_ready", 64'(rd_ready[0]), 64'd1);
        check("pend_cnt_zero", 64'(pend_cnt), 64'd0); advance();

        // WAW stall on r7
        rd_addr[1] = AW'(7);
        claim(7);
        step();
        repeat (2) begin
            sample(); check("waw_stall", 64'(iss_ready), 64'd0); advance();
        end
        wb(0, 7, 64'h7777);
        sample(); check("waw_stall_wb", 64'(iss_ready), 64'd0); advance();
        // r7 free now: claim and write back in the same cycle
        wb(0, 7, 64'h8888);
        sample(); check("waw_free", 64'(iss_ready), 64'd1); advance();
        idle();
        sample(); check("set_wins_rd", 64'(rd_ready[1]), 64'd0);
        check("set_wins_iss", 64'(iss_ready), 64'd0); advance();
        wb(0, 7, 64'h9999);
        step();
        idle();

        // Write port priority on r9
        claim(9);
        step();
        idle();
        rd_addr[2] = AW'(9);
        wb(0, 9, 64'd1);
        wb(1, 9, 64'd2);
        step();
        idle();
        sample(); check("prio_r9", rd_data[2], 64'd2); advance();

        // Register 0 and sticky wb_err
        do_reset(2);
        rd_addr[0] = AW'(0);
        wb(0, 0, 64'hFF);
        step();
        idle();
        sample(); check("r0_zero", rd_data[0], 64'd0);
        check("r0_no_err", 64'(wb_err), 64'd0); advance();
        wb(1, 12, 64'h1234);
        step();
        idle();
        repeat (3) begin
            sample(); check("err_sticky", 64'(wb_err), 64'd1); advance();
        end
        do_reset(1);
        sample(); check("err_cleared", 64'(wb_err), 64'd0); advance();

        // Same-cycle forwarding of r3
        claim(3);
        step();
        idle();
        rd_addr[1] = AW'(3);
        wb(0, 3, 64'h42);
        sample();
        check("byp_data", rd_data[1], BYP ? 64'h42 : 64'd0);
        check("byp_ready", 64'(rd_ready[1]), 64'(BYP));
        advance();
        idle();

        // Randomized traffic
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < NUM_RD; i++) rd_addr[i] = AW'($urandom_range(0, NUM_REGS - 1));
            iss_valid = ($urandom_range(0, 1) == 1);
            iss_dst   = AW'($urandom_range(0, NUM_REGS - 1));
            plist.delete();
            for (int r = 0; r < NUM_REGS; r++) if (m_pend[r]) plist.push_back(r);
            for (int j = 0; j < NUM_WR; j++) begin
                wb_valid[j] = ($urandom_range(0, 9) < 4);
                if (plist.size() > 0 && $urandom_range(0, 3) != 0)
                    wb_addr[j] = AW'(plist[$urandom_range(0, plist.size() - 1)]);
                else
                    wb_addr[j] = AW'($urandom_range(0, NUM_REGS - 1));
                wb_data[j] = {$urandom(), $urandom()};
            end
            step();
        end
        reset = 1'b1;
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_tinker_regfile_sb
`default_nettype wire

// File: doc/tinker_regfile_sb.md
# tinker_regfile_sb

- Parametrised multi-port register file with an integrated pending-write scoreboard.
- Serves as the architectural register state for the pipelined Tinker core, replacing the single-cycle register file.
- Provides N combinational read ports and W write-back ports, and tracks which registers have an in-flight producer so the issue stage can stall on RAW/WAW hazards.
- Exposes the stack pointer and hazard status.

## Interface
Parameters:
- DATA_W, 64, register width in bits
- NUM_REGS, 32, number of architectural registers (power of two)
- NUM_RD, 3, number of read ports (rd, rs, rt)
- NUM_WR, 2, number of write-back ports
- SP_IDX, 31, index of stack-pointer register
- SP_RESET, 524288, reset value of register SP_IDX

Ports (AW = $clog2(NUM_REGS)):
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (0 = reset)
- rd_addr  in  NUM_RD×AW  read addresses
- rd_data  out  NUM_RD×DATA_W  read data
- rd_ready  out  NUM_RD  1 = operand valid (no pending producer)
- iss_valid  in  1  issue stage claims a destination this cycle
- iss_dst  in  AW  destination being claimed
- iss_ready  out  1  1 = claim accepted (iss_dst not pending)
- wb_valid  in  NUM_WR  write-back strobe per port
- wb_addr  in  NUM_WR×AW  write-back register index
- wb_data  in  NUM_WR×DATA_W  write-back data
- stack_ptr  out  DATA_W  current value of register SP_IDX
- pend_cnt  out  AW+1  number of pending registers
- wb_err  out  1  sticky: write-back hit a non-pending register

## Operation
- Reset (reset==0 at a clock edge):
  - All registers go to 0, except SP_IDX, which goes to SP_RESET.
  - pending vector, pend_cnt and wb_err go to 0.
  - Write-back and issue in the same cycle are ignored.
- Register 0:
  - Always reads 0 and is never pending.
  - Writes to it are dropped; claims of it are accepted with no effect.
  - A write-back to it never sets wb_err.
- Write: each wb_valid[j] writes wb_data[j] into wb_addr[j] at the edge.
  - If two ports target the same address, the higher-indexed port wins.
- Scoreboard:
  - iss_valid && iss_ready sets pending[iss_dst].
  - wb_valid[j] clears pending[wb_addr[j]].
  - Set and clear of the same register in the same cycle: set wins, because the new producer supersedes.
- iss_ready = !pending[iss_dst] (WAW stall). It is independent of iss_valid.
- rd_ready[i] = !pending[rd_addr[i]]. With bypass enabled (see Configuration), it is also 1 if any wb_valid[j] matches rd_addr[i] this cycle.
- wb_err:
  - Set when wb_valid[j] targets a nonzero register whose pending bit is 0.
  - Cleared only by reset.
  - The write itself still happens.
- pend_cnt equals the population count of the registered pending vector.

## Timing
- Reads are combinational from current register state. Latency is 0 cycles.
- A write becomes visible to reads on the cycle after wb_valid. With bypass enabled, it is visible in the same cycle.
- A claim becomes visible in rd_ready, iss_ready and pend_cnt on the cycle after acceptance.
- stack_ptr is registered state and reflects a write to SP_IDX on the following cycle. It is never bypassed.
- All outputs are valid one cycle after reset deasserts, with values as listed under reset.

## Configuration
- Macro: TINKER_RF_BYPASS_EN
- Defined:
  - rd_data[i] forwards the winning same-cycle wb_data for a matching rd_addr[i] (register 0 excluded).
  - rd_ready[i] is asserted for such matches.
- Undefined:
  - No forwarding paths.
  - rd_data shows only stored state.
  - rd_ready depends only on the registered pending vector.

## Structure
- Shared package tinker_pkg holds:
  - NUM_REGS, REG_AW, SP_IDX, SP_RESET
  - typedef reg_idx_t (logic [REG_AW-1:0])
  - typedef word_t (logic [63:0])
- One sub-module: tinker_scoreboard. It holds the pending vector, set/clear priority, iss_ready, pend_cnt and wb_err.
- The top level owns register storage, write-port priority and the bypass mux.

## Test plan
- Reset:
  - Stimulus: hold reset=0 for 2 cycles, then release.
  - Required: r0–r30 read 0; stack_ptr = 524288; pend_cnt = 0; wb_err = 0.
- Claim and write-back:
  - Stimulus: claim r5, then wb_valid[0] with r5 = 64'hDEAD two cycles later.
  - Required: rd_ready for r5 is 0 for 2 cycles; the next cycle reads 64'hDEAD with ready = 1; pend_cnt goes 1 → 0.
- WAW stall:
  - Stimulus: claim r7, then reissue r7 the next cycle.
  - Required: iss_ready = 0 until write-back. Set and clear of r7 in the same cycle leaves r7 pending.
- Port priority:
  - Stimulus: wb port 0 writes r9 = 1 and port 1 writes r9 = 2 in the same cycle.
  - Required: r9 reads 2 the next cycle.
- r0 and wb_err:
  - Stimulus: write 64'hFF to r0, then write r12 without a prior claim.
  - Required: r0 still reads 0; wb_err stays 1 after the r12 write until reset.
- Bypass (TINKER_RF_BYPASS_EN defined):
  - Stimulus: pending r3 is written back with 64'h42 while rd_addr[1] = 3.
  - Required: rd_data[1] = 64'h42 and rd_ready[1] = 1 in that same cycle. Without the macro, rd_ready[1] = 0 in that cycle.
